// File: rtl/lab2_proc_int_muldiv_iter_if.sv
// Request/response stream bundle for the iterative integer multiply/divide unit.
//   istream_val/istream_rdy/istream_msg : request handshake, msg = {fn[2:0], a[31:0], b[31:0]}
//   ostream_val/ostream_rdy/ostream_msg : result handshake, msg = 32-bit result
// master: the requester/consumer side; slave: the arithmetic unit.
interface lab2_proc_int_muldiv_iter_if;
  logic        istream_val;
  logic        istream_rdy;
  logic [66:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] ostream_msg;

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/lab2_proc_int_muldiv_iter.sv
// Iterative 32-bit integer multiply / divide unit.
// One operation in flight; every fn takes 32 CALC cycles (33 cycles accept-to-result).
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   io    : request/result streams (see lab2_proc_int_muldiv_iter_if)
// fn: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5..7 illegal (result 0).
module lab2_proc_int_muldiv_iter (
  input  logic                          clk,
  input  logic                          reset,
  lab2_proc_int_muldiv_iter_if.slave    io
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  state_e      state, state_next;
  logic [2:0]  fn;
  logic [31:0] opa;     // MUL: multiplicand (shifts left); DIV: dividend, becomes quotient
  logic [31:0] opb;     // MUL: multiplier (shifts right);  DIV: divisor magnitude
  logic [31:0] acc;     // MUL: accumulator;                DIV: partial remainder
  logic [31:0] a_raw;   // original a, returned unchanged by REM/REMU on divide-by-zero
  logic [31:0] result;
  logic [5:0]  step;
  logic        neg_q, neg_r;

  // Request decode
  logic [2:0]  in_fn;
  logic [31:0] in_a, in_b;
  logic        in_signed;
  assign in_fn     = io.istream_msg[66:64];
  assign in_a      = io.istream_msg[63:32];
  assign in_b      = io.istream_msg[31:0];
  assign in_signed = (in_fn == FN_DIV) || (in_fn == FN_REM);

  logic accept, last_step;
  assign accept    = (state == IDLE) && io.istream_val;
  assign last_step = (state == CALC) && (step == 6'd31);

  // One iteration of each algorithm, plus the final sign/zero fixup.
  logic [31:0] acc_mul, opa_mul, opb_mul;
  logic [32:0] rem_shift, diff;
  logic        fits;
  logic [31:0] acc_div, opa_div;
  logic [31:0] final_res;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_mul   = acc + (opb[0] ? opa : 32'd0);
    opa_mul   = opa << 1;
    opb_mul   = opb >> 1;

    // Restoring step: shift the next dividend bit into the remainder, trial-subtract.
    rem_shift = {acc, opa[31]};
    diff      = rem_shift - {1'b0, opb};
    fits      = ~diff[32];
    acc_div   = fits ? diff[31:0] : rem_shift[31:0];
    opa_div   = {opa[30:0], fits};

    final_res = 32'd0;
    case (fn)
      FN_MUL:          final_res = acc_mul;
      FN_DIV, FN_DIVU: final_res = (opb == 32'd0) ? 32'hFFFF_FFFF
                                 : (neg_q ? -opa_div : opa_div);
      FN_REM, FN_REMU: final_res = (opb == 32'd0) ? a_raw
                                 : (neg_r ? -acc_div : acc_div);
      default:         final_res = 32'd0;
    endcase
  end

  // Next-state and outputs
  always_comb begin
    state_next     = state;
    io.istream_rdy = 1'b0;
    io.ostream_val = 1'b0;
    io.ostream_msg = 32'd0;
    case (state)
      IDLE: begin
        io.istream_rdy = 1'b1;
        if (io.istream_val) state_next = CALC;
      end
      CALC: begin
        if (step == 6'd31) state_next = DONE;
      end
      DONE: begin
        io.ostream_val = 1'b1;
        io.ostream_msg = result;
        if (io.ostream_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every datapath register is cleared on reset, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn     <= 3'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      acc    <= 32'd0;
      a_raw  <= 32'd0;
      result <= 32'd0;
      step   <= 6'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (accept) begin
      fn    <= in_fn;
      // Signed divides work on magnitudes; MUL and unsigned ops take raw operands.
      opa   <= (in_signed && in_a[31]) ? -in_a : in_a;
      opb   <= (in_signed && in_b[31]) ? -in_b : in_b;
      acc   <= 32'd0;
      a_raw <= in_a;
      step  <= 6'd0;
      neg_q <= in_signed && (in_a[31] ^ in_b[31]);
      neg_r <= in_signed && in_a[31];
    end else if (state == CALC) begin
      step <= step + 6'd1;
      case (fn)
        FN_MUL: begin
          acc <= acc_mul;
          opa <= opa_mul;
          opb <= opb_mul;
        end
        FN_DIV, FN_DIVU, FN_REM, FN_REMU: begin
          acc <= acc_div;
          opa <= opa_div;
        end
        default: ;
      endcase
      if (last_step) result <= final_res;
    end
  end

endmodule

// File: doc/lab2_proc_int_muldiv_iter.md
LAB2_PROC_INT_MULDIV_ITER -- requirements
Module: lab2_proc_IntMulDivIter

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have `istream_val`, input, 1 bit: a request is present.
REQ-005 SHALL have `istream_rdy`, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have `istream_msg`, input, 67 bits: [66:64] fn, [63:32] a (op1), [31:0] b (op2).
REQ-007 SHALL have `ostream_val`, output, 1 bit: a result is present.
REQ-008 SHALL have `ostream_rdy`, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have `ostream_msg`, output, 32 bits: the result.
REQ-010 SHALL decode fn as follows:
- 0 = MUL (low 32 bits of a*b)
- 1 = DIV (signed)
- 2 = DIVU
- 3 = REM (signed)
- 4 = REMU
- 5..7 = illegal

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC and DONE; the reset state SHALL be IDLE.
REQ-012 `istream_rdy` SHALL be 1 only in IDLE; `ostream_val` SHALL be 1 only in DONE; at most one operation is in flight.
REQ-013 IDLE -> CALC SHALL occur on istream_val && istream_rdy; at that edge the unit SHALL latch fn, a and b, and clear a 6-bit step counter.
REQ-014 CALC SHALL perform exactly one iteration per cycle for 32 cycles for every fn, then move to DONE; the counter SHALL go 0..31, and the transition occurs on the edge where the counter equals 31.
REQ-015 Latency: a request accepted on edge T SHALL present ostream_val=1 starting at the cycle after edge T+32 (33 cycles accept-to-result), independent of operand values.
REQ-016 MUL SHALL use shift-add: on each step, if the multiplier LSB is 1, add the shifted multiplicand to the accumulator; the multiplicand shifts left by 1 and the multiplier shifts right by 1; the result keeps the low 32 bits and discards wrap-around.
REQ-017 DIV/REM SHALL use restoring division on the magnitudes |a| and |b| (two's complement negate when the operand is negative and fn is signed); DIVU/REMU SHALL use the raw operands.
REQ-018 Sign fixup SHALL be applied on the CALC->DONE edge:
- quotient is negated iff sign(a) XOR sign(b) (signed ops only);
- remainder is negated iff sign(a) (signed ops only).
REQ-019 Divide by zero (b==0) SHALL produce:
- DIV/DIVU result 0xFFFFFFFF;
- REM/REMU result = a unmodified.
This SHALL override the sign fixup.
REQ-020 Signed overflow (a=0x80000000, b=0xFFFFFFFF) SHALL produce DIV 0x80000000 and REM 0x00000000.
REQ-021 An illegal fn SHALL still take 33 cycles and return 0x00000000.
REQ-022 In DONE, ostream_msg SHALL hold constant until ostream_val && ostream_rdy; on that edge the FSM SHALL move to IDLE, with istream_rdy=1 in the next cycle (no same-cycle accept in DONE).
REQ-023 While ostream_rdy=0, DONE SHALL stall indefinitely with no change to ostream_msg.
REQ-024 istream_val asserted while not in IDLE SHALL be ignored, with no state change.
REQ-025 Outside DONE, ostream_msg SHALL be 0.

Reset
REQ-026 reset=1 on any edge SHALL force IDLE, counter=0 and all operand/accumulator registers to 0, including mid-CALC or in DONE; the in-flight operation is discarded and no result is emitted.
REQ-027 The unit SHALL show istream_rdy=1, ostream_val=0 and ostream_msg=0 in the first cycle after reset deasserts.
REQ-028 reset SHALL take priority over simultaneous istream or ostream handshakes.

Verification
REQ-029 The bench SHALL cover MUL, ready always high:
- a=0xFFFFFFFF (-1), b=7 -> 0xFFFFFFF9 at exactly 33 cycles after accept;
- a=0x00010000, b=0x00010000 -> 0x00000000 (wrap-around).
REQ-030 The bench SHALL cover signed DIV/REM:
- a=-7, b=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF;
- DIVU a=0xFFFFFFF9, b=2 -> 0x7FFFFFFC.
REQ-031 The bench SHALL cover corner cases:
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000;
- REM of the same operands -> 0;
- DIV 5/0 -> 0xFFFFFFFF;
- REMU 5/0 -> 5;
- REM -5/0 -> 0xFFFFFFFB.
REQ-032 The bench SHALL cover backpressure:
- hold ostream_rdy=0 for 10 cycles in DONE -> ostream_val=1 with a stable msg, and istream_rdy=0 throughout;
- raise rdy -> IDLE in the next cycle.
REQ-033 The bench SHALL cover reset mid-operation: assert reset at step 15 of a MUL, then issue MUL 3*4 -> only 0x0000000C is ever emitted.
REQ-034 The bench SHALL cover back-to-back requests with istream_val held high: two MULs complete with results in order; the second is accepted exactly one cycle after the first output handshake.
